// File: rtl/ncpu32k_bpu_upd_sched_if.sv
// Bundle between resolved-branch requesters, the update scheduler and the predictor write port.
// Master = requester/predictor side, slave = scheduler.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

interface ncpu32k_bpu_upd_sched_if #(
  parameter int DEPTH = 4,
  parameter int PCW   = `NCPU_AW-2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [PCW-1:0] req0_pc,    req1_pc;
  logic           req0_taken, req1_taken;
  logic [PCW-1:0] req0_tgt,   req1_tgt;
  logic           flush;
  logic           bpu_wb;
  logic           bpu_wb_ready;
  logic [PCW-1:0] bpu_wb_insn_pc;
  logic           bpu_wb_taken;
  logic [PCW-1:0] bpu_wb_tgt;
  logic [CW-1:0]  upd_count;

  modport master (
    output req0_valid, req1_valid, req0_pc, req1_pc, req0_taken, req1_taken,
           req0_tgt, req1_tgt, flush, bpu_wb_ready,
    input  req0_ready, req1_ready, bpu_wb, bpu_wb_insn_pc, bpu_wb_taken,
           bpu_wb_tgt, upd_count
  );

  modport slave (
    input  req0_valid, req1_valid, req0_pc, req1_pc, req0_taken, req1_taken,
           req0_tgt, req1_tgt, flush, bpu_wb_ready,
    output req0_ready, req1_ready, bpu_wb, bpu_wb_insn_pc, bpu_wb_taken,
           bpu_wb_tgt, upd_count
  );
endinterface

// File: rtl/ncpu32k_bpu_upd_sched.sv
// Two-requester branch-predictor update scheduler: round-robin arbitration into a
// small in-order FIFO that drains to the predictor write port.
module ncpu32k_bpu_upd_sched #(
  parameter int DEPTH = 4,
  parameter int PCW   = `NCPU_AW-2
) (
  input logic                     clk,
  input logic                     rst,
  ncpu32k_bpu_upd_sched_if.slave  u
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           taken;
    logic [PCW-1:0] tgt;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic          acc, gnt0, gnt1, push, pop, wb;
  ent_t          wr_ent;

  always_comb begin
    acc    = (cnt_q != FULL_CNT) && !u.flush;
    gnt0   = acc && u.req0_valid && (!u.req1_valid || !rr_q);
    gnt1   = acc && u.req1_valid && (!u.req0_valid ||  rr_q);
    push   = gnt0 || gnt1;
    wb     = (cnt_q != '0) && !u.flush;
    pop    = wb && u.bpu_wb_ready;
    wr_ent = gnt1 ? '{pc: u.req1_pc, taken: u.req1_taken, tgt: u.req1_tgt}
                  : '{pc: u.req0_pc, taken: u.req0_taken, tgt: u.req0_tgt};

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    // Pointer always ends up on the requester that lost (or was absent).
    rr_d   = push ? gnt0 : rr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (u.flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rr_q   <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  // Storage is deliberately unreset; upd_count alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_ent;
  end

  assign u.req0_ready     = gnt0;
  assign u.req1_ready     = gnt1;
  assign u.bpu_wb         = wb;
  assign u.bpu_wb_insn_pc = mem_q[rptr_q].pc;
  assign u.bpu_wb_taken   = mem_q[rptr_q].taken;
  assign u.bpu_wb_tgt     = mem_q[rptr_q].tgt;
  assign u.upd_count      = cnt_q;
endmodule

// File: tb/tb_ncpu32k_bpu_upd_sched.sv
// Vector-table bench for the branch update scheduler with an in-order scoreboard
// of accepted updates checked against the predictor write port.
module tb_ncpu32k_bpu_upd_sched;
  localparam int PCW = 30;
  localparam int CW  = 3;
  typedef logic [PCW-1:0] pc_t;

  typedef struct {
    logic rst, flush, v0, v1;
    pc_t  pc0, tgt0, pc1, tgt1;
    logic tk0, tk1, wbr;
    logic er0, er1, ewb;
    logic [CW-1:0] ecnt;
  } vec_t;

  typedef struct packed {
    pc_t  pc;
    logic tk;
    pc_t  tgt;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ncpu32k_bpu_upd_sched_if #(.DEPTH(4), .PCW(PCW)) bif();
  ncpu32k_bpu_upd_sched #(.DEPTH(4), .PCW(PCW)) dut (.clk(clk), .rst(rst), .u(bif));

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic a, logic b, pc_t p0, pc_t p1,
                              logic w, logic e0, logic e1, logic ew, int c);
    vec_t v;
    v.rst = r; v.flush = f; v.v0 = a; v.v1 = b;
    v.pc0 = p0; v.tk0 = p0[0]; v.tgt0 = p0 + pc_t'('h40);
    v.pc1 = p1; v.tk1 = p1[0]; v.tgt1 = p1 + pc_t'('h40);
    v.wbr = w; v.er0 = e0; v.er1 = e1; v.ewb = ew; v.ecnt = CW'(c);
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, update scoreboard.
  task automatic step(vec_t v, int idx);
    ent_t e;
    rst = v.rst;
    bif.flush = v.flush; bif.req0_valid = v.v0; bif.req1_valid = v.v1;
    bif.req0_pc = v.pc0; bif.req0_taken = v.tk0; bif.req0_tgt = v.tgt0;
    bif.req1_pc = v.pc1; bif.req1_taken = v.tk1; bif.req1_tgt = v.tgt1;
    bif.bpu_wb_ready = v.wbr;
    #4;
    if (!v.rst) begin
      chk("req0_ready", idx, 32'(bif.req0_ready), 32'(v.er0));
      chk("req1_ready", idx, 32'(bif.req1_ready), 32'(v.er1));
      chk("bpu_wb",     idx, 32'(bif.bpu_wb),     32'(v.ewb));
      chk("upd_count",  idx, 32'(bif.upd_count),  32'(v.ecnt));
      if (v.ewb && v.wbr && !v.flush) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow @%0d got=pop want=no_pop", idx);
        end else begin
          e = sb.pop_front();
          chk("wb_pc",    idx, 32'(bif.bpu_wb_insn_pc), 32'(e.pc));
          chk("wb_taken", idx, 32'(bif.bpu_wb_taken),   32'(e.tk));
          chk("wb_tgt",   idx, 32'(bif.bpu_wb_tgt),     32'(e.tgt));
        end
      end
      if (v.er0 && v.v0) sb.push_back('{pc: v.pc0, tk: v.tk0, tgt: v.tgt0});
      if (v.er1 && v.v1) sb.push_back('{pc: v.pc1, tk: v.tk1, tgt: v.tgt1});
    end
    if (v.rst || v.flush) sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t t;
    int   mcnt, pushes;
    rst = 1'b1;
    bif.flush = 0; bif.req0_valid = 0; bif.req1_valid = 0; bif.bpu_wb_ready = 0;
    bif.req0_pc = '0; bif.req0_taken = 0; bif.req0_tgt = '0;
    bif.req1_pc = '0; bif.req1_taken = 0; bif.req1_tgt = '0;

    //        rst f  v0 v1 pc0     pc1     wbr r0 r1 wb cnt
    tbl.push_back(mk(1, 0, 0, 0, 'h000, 'h000, 0, 0, 0, 0, 0));
    // both valid, predictor stalled: r0,r1,r0,r1 then full
    tbl.push_back(mk(0, 0, 1, 1, 'h100, 'h200, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 'h101, 'h201, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 'h102, 'h202, 0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 1, 'h103, 'h203, 0, 0, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 1, 'h104, 'h204, 0, 0, 0, 1, 4));
    // full + pop: nothing accepted, then req0 fits
    tbl.push_back(mk(0, 0, 1, 0, 'h105, 'h000, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 1, 0, 'h300, 'h000, 0, 1, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 1, 1));
    // 0x10/T/0x40 then 0x20/NT/0x0 through a ready predictor
    t = mk(0, 0, 1, 0, 'h10, 'h000, 1, 1, 0, 0, 0); t.tk0 = 1; t.tgt0 = 'h40; tbl.push_back(t);
    t = mk(0, 0, 1, 0, 'h20, 'h000, 1, 1, 0, 1, 1); t.tk0 = 0; t.tgt0 = 'h0;  tbl.push_back(t);
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 1, 1));
    // fill 3, flush with both valid; rr pointer must survive the flush
    tbl.push_back(mk(0, 0, 1, 0, 'h500, 'h000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 'h501, 'h601, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 'h502, 'h602, 0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 1, 1, 1, 'h503, 'h603, 1, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 1, 'h504, 'h604, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 1, 1));
    // reset together with flush and push clears everything incl. rr pointer
    tbl.push_back(mk(0, 0, 1, 0, 'h700, 'h000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 'h701, 'h801, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 'h702, 'h802, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 0, 0, 0, 1, 1));
    // mid-operation reset discards the queued entry
    tbl.push_back(mk(1, 0, 0, 0, 'h000, 'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h000, 'h000, 1, 0, 0, 0, 0));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // 6 pushes / 6 pops interleaved across the pointer wrap, checked against a count model
    mcnt = 0; pushes = 0;
    for (int i = 0; i < 14; i++) begin
      t = mk(0, 0, pushes < 6, 0, pc_t'('h900 + i), 'h000,
             (i % 2 == 1) || (i >= 6), 0, 0, mcnt != 0, mcnt);
      t.er0 = t.v0 && (mcnt < 4);
      step(t, 100 + i);
      if (t.er0) begin pushes++; mcnt++; end
      if (t.ewb && t.wbr) mcnt--;
      chk("cnt_le_depth", 100 + i, 32'(bif.upd_count <= 3'd4), 32'd1);
    end
    chk("sb_drained", 200, 32'(sb.size()), 32'd0);
    chk("wrap_pushes", 201, 32'(pushes), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ncpu32k_bpu_upd_sched.md
NCPU32K_BPU_UPD_SCHED -- requirements
Module: ncpu32k_bpu_upd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter PCW, default `NCPU_AW-2, meaning word-PC and target width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset: synchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  meaning requester N offers a resolved-branch update.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  meaning requester N's update is accepted this cycle.
REQ-007 SHALL have ports req0_pc / req1_pc  input  PCW  meaning the branch instruction word-PC.
REQ-008 SHALL have ports req0_taken / req1_taken  input  1  meaning the resolved direction.
REQ-009 SHALL have ports req0_tgt / req1_tgt  input  PCW  meaning the resolved word-target.
REQ-010 SHALL have port flush  input  1  meaning discard all queued updates.
REQ-011 SHALL have port bpu_wb  output  1  meaning an update is presented to the predictor.
REQ-012 SHALL have port bpu_wb_ready  input  1  meaning the predictor consumes the presented update this cycle.
REQ-013 SHALL have ports bpu_wb_insn_pc, bpu_wb_tgt  output  PCW and bpu_wb_taken  output  1  meaning the head entry fields.
REQ-014 SHALL have port upd_count  output  log2(DEPTH)+1  meaning the current number of queued entries.

Function
REQ-015 SHALL hold a circular FIFO of DEPTH entries {pc, taken, tgt} with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 SHALL accept at most one request per cycle; a request is granted only when the FIFO is not full and flush=0.
REQ-017 SHALL grant the only valid requester when one requester is valid.
REQ-018 SHALL resolve both valid requesters by a 1-bit round-robin pointer: pointer=0 grants req0, pointer=1 grants req1.
REQ-019 SHALL, after any grant, set the pointer to the index of the requester not granted; the pointer is unchanged in cycles without a grant.
REQ-020 SHALL drive reqN_ready combinationally as (grantN); a handshake (valid & ready) writes the entry at the write pointer and advances it at the next edge.
REQ-021 SHALL compute full as upd_count==DEPTH, so that a cycle that pops while full accepts nothing; no bypass from request to bpu_wb.
REQ-022 SHALL drive bpu_wb = (upd_count!=0) & !flush, with the bpu_wb_* fields taken from the entry at the read pointer.
REQ-023 SHALL pop on bpu_wb & bpu_wb_ready; it shall hold the head fields stable while bpu_wb=1 and bpu_wb_ready=0.
REQ-024 SHALL update upd_count with push and pop in the same cycle as +0, push only as +1, and pop only as -1.
REQ-025 SHALL present entries to the predictor in exact acceptance order.
REQ-026 SHALL, on flush=1, force both reqN_ready=0 and bpu_wb=0 that cycle.
REQ-027 SHALL, on flush=1, zero both pointers and upd_count at the next edge; the round-robin pointer is preserved.
REQ-028 SHALL leave entry contents unreset; valid data is defined solely by upd_count.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, clear both pointers, upd_count and the round-robin pointer to 0; rst dominates flush and all handshakes.
REQ-030 SHALL drive bpu_wb=0, req0_ready=1 and req1_ready=0 in the cycle after reset when both requesters are valid (pointer=0).
REQ-031 SHALL discard any partially filled queue when rst is asserted mid-operation; no update survives reset.

Verification
REQ-032 SHALL pass this test: after reset, req0 and req1 valid every cycle with bpu_wb_ready=0 -> grants in the order r0,r1,r0,r1; upd_count reaches 4; both readys are 0 in cycle 5.
REQ-033 SHALL pass this test: push pc=0x10/taken=1/tgt=0x40, then pc=0x20/taken=0/tgt=0x0, bpu_wb_ready=1 -> bpu_wb shows 0x10 then 0x20 in consecutive cycles, and upd_count returns to 0.
REQ-034 SHALL pass this test: with the FIFO full (4 entries), bpu_wb_ready=1 and req0_valid=1 -> no accept that cycle, count=3 next cycle, and req0 is accepted the following cycle with count=4.
REQ-035 SHALL pass this test: with 3 entries queued, flush=1 for one cycle with both requesters valid -> readys=0 and bpu_wb=0 that cycle, and count=0 next cycle.
REQ-036 SHALL pass this test: with 6 pushes and 6 pops interleaved (pointer wrap) -> output order equals input order, and count never exceeds 4.
REQ-037 SHALL pass this test: rst=1 asserted together with flush=1 and push -> all counters are 0 next cycle, and the round-robin pointer is 0.
